timer_irq_device: RTL



---
 rtl/timer_irq_device_pkg.sv | 33 +++
 rtl/timer_irq_device.sv | 112 +++++++++++
 2 files changed

// File: rtl/timer_irq_device_pkg.sv
// Shared constants for the countdown timer: register offsets, CTRL bit
// positions, FSM state codes and mode codes.
package timer_irq_device_pkg;

  // Word offsets seen on Addr (byte address bits [3:2])
  localparam logic [1:0] TIMER_CTRL   = 2'd0;
  localparam logic [1:0] TIMER_PRESET = 2'd1;
  localparam logic [1:0] TIMER_COUNT  = 2'd2;

  // CTRL register bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_RELOAD  = 2'b01
  } mode_e;

  // Only mode 01 auto-reloads; 00, 10 and 11 all behave as one-shot.
  function automatic logic is_reload(input logic [3:0] ctrl);
    return ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_irq_device.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers on the device
// bus plus a four-state FSM that loads, counts down and flags expiry.
module timer_irq_device
  import timer_irq_device_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             irq_flag_q, irq_flag_d;
  state_e           state_q, state_d;
  logic             ctrl_wr;

  // State register; reset acts immediately, independent of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      state_q    <= state_d;
    end
  end

  // Bus writes first, then the FSM; the FSM's flag set is applied last so it
  // wins over a coincident clearing write, while a bus CTRL write is protected
  // from the one-shot Enable clear.
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    state_d    = state_q;
    ctrl_wr    = We && (Addr == TIMER_CTRL);

    if (We) begin
      case (Addr)
        TIMER_CTRL: begin
          ctrl_d     = DIn[3:0];
          irq_flag_d = 1'b0;
        end
        TIMER_PRESET: begin
          preset_d   = DIn[CNT_W-1:0];
          irq_flag_d = 1'b0;
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = ST_IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          // A zero preset lands here too, so it expires after one CNT cycle.
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (is_reload(ctrl_q)) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          if (!ctrl_wr) ctrl_d[CTRL_EN] = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Combinational read mux; unused upper bits and the reserved offset read 0.
  always_comb begin
    DOut = '0;
    case (Addr)
      TIMER_CTRL:   DOut[3:0]       = ctrl_q;
      TIMER_PRESET: DOut[CNT_W-1:0] = preset_q;
      TIMER_COUNT:  DOut[CNT_W-1:0] = count_q;
      default:      DOut            = '0;
    endcase
  end

  assign IRQ = irq_flag_q & ctrl_q[CTRL_IM];

endmodule
